dac_tone_gen: RTL and testbench
===============================

# dac_tone_gen

Parametrised NCO-based test-tone generator for the video DAC path. A phase accumulator drives a sine lookup or a synthetic waveform. The result is scaled by amplitude, offset and saturated to the DAC width. It adds square/sawtooth/DC modes, a linear frequency sweep, and a glitch-free configuration handshake that applies new settings only at a phase wrap. It sits between the PLL clock domain and the `video` DAC pins, replacing fixed-constant tone generation.

## Interface
- `PHASE_WIDTH`, 32: phase accumulator / tuning word width.
- `LUT_ADDR_BITS`, 5: sine table address width, taken from phase MSBs.
- `DAC_WIDTH`, 8: output width, unsigned.
- `clk` in 1: sole clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset; one clock, reset asynchronous active-high.
- `enable` in 1: run generator; low forces IDLE.
- `cfg_valid` in 1: config word offered.
- `cfg_ready` out 1: config can be accepted.
- `cfg_mode` in 3: 0 DC, 1 SINE, 2 SQUARE, 3 SAW, 4 SWEEP (sine carrier); 5-7 treated as DC.
- `cfg_ftw` in PHASE_WIDTH: tuning word (sweep start in SWEEP).
- `cfg_ftw_stop`, `cfg_ftw_step` in PHASE_WIDTH: sweep end / increment.
- `cfg_dwell` in 16: sweep dwell; each step held dwell+1 cycles.
- `cfg_repeat` in 1: sweep restarts at start after reaching stop.
- `cfg_amplitude` in 8: unsigned gain.
- `cfg_offset` in DAC_WIDTH: unsigned DC level.
- `dac_out` out DAC_WIDTH: registered DAC code.
- `ftw_current` out PHASE_WIDTH: active tuning word.
- `phase_wrap` out 1: one-cycle pulse when accumulator overflows.
- `sweep_done` out 1: one-cycle pulse when sweep reaches stop.

## Operation
- Reset: all outputs 0, `cfg_ready`=1, active config all-zero (mode DC), FSM IDLE, phase 0.
- Config transfer on `cfg_valid && cfg_ready` into a staging register. `cfg_ready` drops the next cycle and stays low while staging is pending.
- Staged config becomes active in IDLE immediately (next cycle), otherwise on the cycle `phase_wrap` fires. Phase is not reset on apply, so there is no phase discontinuity. `cfg_ready` rises the cycle after apply.
- Apply in SWEEP loads `ftw_current`=`cfg_ftw` and clears the dwell counter.
- FSM states: IDLE, RUN, SWEEP, HOLD.
  - IDLE: `enable` low. Phase held at 0.
  - IDLE->RUN: `enable` high and mode≠SWEEP.
  - IDLE->SWEEP: `enable` high and mode=SWEEP.
  - SWEEP->HOLD: stop reached with `cfg_repeat`=0.
  - Any state->IDLE when `enable` falls. This takes priority over everything else.
- Phase: `phase <= phase + ftw_current`, modulo 2^PHASE_WIDTH. `phase_wrap` pulses when the carry-out is set.
- Sweep: the dwell counter counts 0..dwell. At dwell, `ftw_current += step`. If the result ≥ stop (unsigned, carry included), it is clamped to stop and `sweep_done` pulses.
  - With `cfg_repeat`=1, the next step reloads the start value.
  - Without repeat, the FSM goes to HOLD and keeps the tone at stop.
  - step=0: no change, `sweep_done` never fires.
  - start ≥ stop: clamps to stop on the first step.
- Waveform, signed 8-bit, range ±127:
  - SINE: LUT of 2^LUT_ADDR_BITS entries, round(127·sin(2πk/N)).
  - SQUARE: +127 if phase MSB=0, else -127.
  - SAW: top 8 phase bits minus 128, with -128 clamped to -127.
  - DC: 0.
- Scale: signed product wave·amplitude (16-bit), arithmetic shift right by 7 (floor), giving a 10-bit signed value.
- Sum: offset + scaled, saturated to [0, 2^DAC_WIDTH−1].
- In IDLE `dac_out` = `cfg_offset` of the active config, with pipeline latency preserved.

## Timing
- Pipeline from the phase register to `dac_out`: 3 registers (lookup, scale, offset/saturate).
- A phase value appears on `dac_out` 3 cycles after it is registered.
- Enabling from IDLE: first non-DC sample appears 4 cycles after the `enable` rising edge.
- `ftw_current` changes the cycle after the dwell terminal count. `sweep_done` is asserted in the same cycle as the clamped value.
- `cfg_valid` held with `cfg_ready` low: no transfer, and the staged word is not overwritten.
- Reset mid-operation: pipeline, staging and pending config are cleared immediately. No pulse outputs occur during reset.

## Structure
- Package `dac_tone_pkg`: mode enum, FSM state enum, the waveform width constant 8, and the scale shift constant 7.
- Sub-module `tone_sine_lut`: registered signed sine ROM, parametrised by LUT_ADDR_BITS, computed at elaboration.

## Test plan
- SINE, ftw=0x0800_0000 (period 32), amp=12, offset=100, PHASE_WIDTH=32 -> `dac_out` period 32, min 88, max 111, `phase_wrap` every 32 cycles.
- SQUARE, amp=255, offset=250 -> `dac_out` alternates 255/0 (saturation on both rails), 16 cycles each at ftw=0x0800_0000.
- SWEEP, start=0x100, stop=0x400, step=0x100, dwell=3, repeat=0 -> `ftw_current` 0x100,0x200,0x300,0x400 each held 4 cycles; single `sweep_done` pulse; then HOLD at 0x400.
- Config while RUN -> `cfg_ready` low from accept to the next `phase_wrap`; new amplitude takes effect exactly 3 cycles after that wrap; a second `cfg_valid` during pending is ignored.
- `enable` low mid-sweep, then `rst` pulse mid-cycle -> IDLE, `dac_out`=offset after 3 cycles; after reset all outputs 0 and `cfg_ready`=1.

Source files
------------

// File: rtl/dac_tone_pkg.sv
// Shared types and constants for the DAC test-tone generator.
// Imported by the top, the sine ROM and the testbench.
package dac_tone_pkg;

  typedef enum logic [2:0] {
    MODE_DC     = 3'd0,
    MODE_SINE   = 3'd1,
    MODE_SQUARE = 3'd2,
    MODE_SAW    = 3'd3,
    MODE_SWEEP  = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SWEEP,
    ST_HOLD
  } state_e;

  localparam int WAVE_W      = 8;
  localparam int SCALE_SHIFT = 7;

endpackage

// File: rtl/dac_tone_gen_if.sv
// Configuration handshake bundle for the tone generator.
// The config producer is master, the generator is slave.
interface dac_tone_gen_if #(
  parameter int PHASE_WIDTH = 32,
  parameter int DAC_WIDTH   = 8
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [2:0]             cfg_mode;
  logic [PHASE_WIDTH-1:0] cfg_ftw;
  logic [PHASE_WIDTH-1:0] cfg_ftw_stop;
  logic [PHASE_WIDTH-1:0] cfg_ftw_step;
  logic [15:0]            cfg_dwell;
  logic                   cfg_repeat;
  logic [7:0]             cfg_amplitude;
  logic [DAC_WIDTH-1:0]   cfg_offset;

  modport master (
    output cfg_valid, cfg_mode, cfg_ftw,
    output cfg_ftw_stop, cfg_ftw_step,
    output cfg_dwell, cfg_repeat,
    output cfg_amplitude, cfg_offset,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_ftw,
    input  cfg_ftw_stop, cfg_ftw_step,
    input  cfg_dwell, cfg_repeat,
    input  cfg_amplitude, cfg_offset,
    output cfg_ready
  );
endinterface

// File: rtl/tone_sine_lut.sv
// Registered signed sine ROM, one full period of 2^ADDR_BITS
// entries, contents computed at elaboration.
module tone_sine_lut
  import dac_tone_pkg::*;
#(
  parameter int ADDR_BITS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_BITS-1:0]     addr,
  output logic signed [WAVE_W-1:0] data
);
  localparam int  N  = 2 ** ADDR_BITS;
  localparam real PI = 3.14159265358979;

  function automatic logic signed [WAVE_W-1:0] entry(
    input int k
  );
    real x;
    int  r;
    x = 127.0 * $sin(2.0 * PI * real'(k) / real'(N));
    r = (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
    return WAVE_W'(r);
  endfunction

  logic signed [WAVE_W-1:0] rom [N];

  for (genvar k = 0; k < N; k++) begin : g_rom
    assign rom[k] = entry(k);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data <= '0;
    else     data <= rom[addr];
  end
endmodule

// File: rtl/dac_tone_gen.sv
// NCO test-tone generator: phase accumulator, waveform select,
// amplitude scale, offset and saturate into the video DAC.
module dac_tone_gen
  import dac_tone_pkg::*;
#(
  parameter int PHASE_WIDTH   = 32,
  parameter int LUT_ADDR_BITS = 5,
  parameter int DAC_WIDTH     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  dac_tone_gen_if.slave          cfg,
  output logic [DAC_WIDTH-1:0]   dac_out,
  output logic [PHASE_WIDTH-1:0] ftw_current,
  output logic                   phase_wrap,
  output logic                   sweep_done
);
  localparam int PW = PHASE_WIDTH;
  localparam int SW =
    (DAC_WIDTH > WAVE_W ? DAC_WIDTH : WAVE_W) + 3;
  localparam logic signed [SW-1:0] DMAX =
    SW'((2 ** DAC_WIDTH) - 1);

  state_e               state;
  logic [PW-1:0]        phase;
  logic                 run_q, pending, at_stop;
  logic [15:0]          dwell_cnt;

  logic [2:0]           s_mode, a_mode;
  logic [PW-1:0]        s_ftw, s_stop, s_step;
  logic [PW-1:0]        a_ftw, a_stop, a_step;
  logic [15:0]          s_dwell, a_dwell;
  logic                 s_rep, a_rep;
  logic [7:0]           s_amp, a_amp;
  logic [DAC_WIDTH-1:0] s_off, a_off;

  logic [PW:0]          acc, nxt;
  logic                 running, wrap, apply, sw_n;
  logic [2:0]           mode_n;

  assign acc     = {1'b0, phase} + {1'b0, ftw_current};
  assign nxt     = {1'b0, ftw_current} + {1'b0, a_step};
  assign running = enable && (state != ST_IDLE);
  assign wrap    = running && acc[PW];
  assign apply   = pending && (state == ST_IDLE || wrap);
  assign mode_n  = apply ? s_mode : a_mode;
  assign sw_n    = (mode_n == MODE_SWEEP);

  assign cfg.cfg_ready = ~pending;

  // Config staging, glitch-free apply, sweep and phase state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      phase       <= '0;
      run_q       <= 1'b0;
      pending     <= 1'b0;
      at_stop     <= 1'b0;
      dwell_cnt   <= '0;
      ftw_current <= '0;
      phase_wrap  <= 1'b0;
      sweep_done  <= 1'b0;
      s_mode <= '0; s_ftw  <= '0; s_stop <= '0;
      s_step <= '0; s_dwell <= '0; s_rep <= 1'b0;
      s_amp  <= '0; s_off  <= '0;
      a_mode <= '0; a_ftw  <= '0; a_stop <= '0;
      a_step <= '0; a_dwell <= '0; a_rep <= 1'b0;
      a_amp  <= '0; a_off  <= '0;
    end else begin
      phase_wrap <= wrap;
      sweep_done <= 1'b0;
      run_q      <= running;

      if (cfg.cfg_valid && !pending) begin
        pending <= 1'b1;
        s_mode  <= cfg.cfg_mode;
        s_ftw   <= cfg.cfg_ftw;
        s_stop  <= cfg.cfg_ftw_stop;
        s_step  <= cfg.cfg_ftw_step;
        s_dwell <= cfg.cfg_dwell;
        s_rep   <= cfg.cfg_repeat;
        s_amp   <= cfg.cfg_amplitude;
        s_off   <= cfg.cfg_offset;
      end

      if (apply) begin
        pending     <= 1'b0;
        a_mode      <= s_mode;
        a_ftw       <= s_ftw;
        a_stop      <= s_stop;
        a_step      <= s_step;
        a_dwell     <= s_dwell;
        a_rep       <= s_rep;
        a_amp       <= s_amp;
        a_off       <= s_off;
        ftw_current <= s_ftw;
        dwell_cnt   <= '0;
        at_stop     <= 1'b0;
      end

      if (!enable) begin
        state     <= ST_IDLE;
        phase     <= '0;
        dwell_cnt <= '0;
        at_stop   <= 1'b0;
      end else if (state == ST_IDLE) begin
        state <= sw_n ? ST_SWEEP : ST_RUN;
      end else begin
        phase <= acc[PW-1:0];
        if (apply) begin
          state <= sw_n ? ST_SWEEP : ST_RUN;
        end else if (state == ST_SWEEP) begin
          if (dwell_cnt != a_dwell) begin
            dwell_cnt <= dwell_cnt + 16'd1;
          end else begin
            dwell_cnt <= '0;
            // Zero step never advances and never finishes.
            if (a_step != '0) begin
              if (at_stop) begin
                ftw_current <= a_ftw;
                at_stop     <= 1'b0;
              end else if (nxt >= {1'b0, a_stop}) begin
                ftw_current <= a_stop;
                sweep_done  <= 1'b1;
                if (a_rep) at_stop <= 1'b1;
                else       state   <= ST_HOLD;
              end else begin
                ftw_current <= nxt[PW-1:0];
              end
            end
          end
        end
      end
    end
  end

  logic [7:0]               p8;
  logic signed [WAVE_W-1:0] wav0, wav1, lut_q, w2;
  logic                     sin1;
  logic [7:0]               amp1;
  logic [DAC_WIDTH-1:0]     off1, off2;
  logic signed [9:0]        sc2;
  logic signed [15:0]       prod, prod_sh;
  logic signed [SW-1:0]     sum;

  assign p8 = phase[PW-1 -: 8];

  always_comb begin
    wav0 = '0;
    if (run_q) begin
      unique case (a_mode)
        MODE_SQUARE:
          wav0 = p8[7] ? -8'sd127 : 8'sd127;
        MODE_SAW:
          wav0 = (p8 == 8'h00) ? -8'sd127
               : $signed({~p8[7], p8[6:0]});
        default: wav0 = '0;
      endcase
    end
  end

  tone_sine_lut #(.ADDR_BITS(LUT_ADDR_BITS)) u_lut (
    .clk  (clk),
    .rst  (rst),
    .addr (phase[PW-1 -: LUT_ADDR_BITS]),
    .data (lut_q)
  );

  assign w2      = sin1 ? lut_q : wav1;
  assign prod    = 16'(w2) * $signed({8'b0, amp1});
  assign prod_sh = prod >>> SCALE_SHIFT;
  assign sum     = $signed({{(SW-DAC_WIDTH){1'b0}}, off2})
                 + SW'(sc2);

  // Amplitude and offset travel with the sample so a new
  // config lands on the first post-wrap sample exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wav1    <= '0;
      sin1    <= 1'b0;
      amp1    <= '0;
      off1    <= '0;
      sc2     <= '0;
      off2    <= '0;
      dac_out <= '0;
    end else begin
      wav1 <= wav0;
      sin1 <= run_q && (a_mode == MODE_SINE ||
                        a_mode == MODE_SWEEP);
      amp1 <= a_amp;
      off1 <= a_off;
      sc2  <= prod_sh[9:0];
      off2 <= off1;
      if (sum[SW-1])       dac_out <= '0;
      else if (sum > DMAX) dac_out <= '1;
      else                 dac_out <= sum[DAC_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_dac_tone_gen.sv
// Directed bench for dac_tone_gen: vector table of steady tones
// plus hand sequences for latency, sweep, reconfig and reset.
module tb_dac_tone_gen;
  import dac_tone_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  dac_out;
  logic [31:0] ftw_current;
  logic        phase_wrap;
  logic        sweep_done;

  int n_tests = 0;
  int n_fail  = 0;

  dac_tone_gen_if #(.PHASE_WIDTH(32), .DAC_WIDTH(8)) cfg_if ();

  dac_tone_gen #(
    .PHASE_WIDTH   (32),
    .LUT_ADDR_BITS (5),
    .DAC_WIDTH     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cfg         (cfg_if),
    .dac_out     (dac_out),
    .ftw_current (ftw_current),
    .phase_wrap  (phase_wrap),
    .sweep_done  (sweep_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] ftw;
    logic [7:0]  amp;
    logic [7:0]  off;
    int          emin;
    int          emax;
    int          ewrap;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [2:0]  m,
                          input logic [31:0] f,
                          input logic [31:0] stp,
                          input logic [31:0] stepv,
                          input logic [15:0] dw,
                          input logic        rp,
                          input logic [7:0]  amp,
                          input logic [7:0]  off);
    int n = 0;
    while (!cfg_if.cfg_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("cfg_ready_wait", cfg_if.cfg_ready, 1);
    cfg_if.cfg_mode      = m;
    cfg_if.cfg_ftw       = f;
    cfg_if.cfg_ftw_stop  = stp;
    cfg_if.cfg_ftw_step  = stepv;
    cfg_if.cfg_dwell     = dw;
    cfg_if.cfg_repeat    = rp;
    cfg_if.cfg_amplitude = amp;
    cfg_if.cfg_offset    = off;
    cfg_if.cfg_valid     = 1'b1;
    tick();
    cfg_if.cfg_valid     = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int mn, mx, nw, n, bad, n2, n3, nd;
    logic [31:0] fd;

    vt[0] = '{MODE_SINE,   32'h0800_0000,  12, 100,  88, 111, 2};
    vt[1] = '{MODE_SQUARE, 32'h0800_0000, 255, 250,   0, 255, 2};
    vt[2] = '{MODE_SAW,    32'h0800_0000, 128, 128,   1, 248, 2};
    vt[3] = '{MODE_DC,     32'h1000_0000, 200,  77,  77,  77, 4};
    vt[4] = '{3'd7,        32'h2000_0000, 200,  33,  33,  33, 8};
    vt[5] = '{MODE_SINE,   32'h0800_0000, 255, 128,   0, 255, 2};
    vt[6] = '{MODE_SINE,   32'h0800_0000,   0,   5,   5,   5, 2};

    rst    = 1'b1;
    enable = 1'b0;
    cfg_if.cfg_valid     = 1'b0;
    cfg_if.cfg_mode      = '0;
    cfg_if.cfg_ftw       = '0;
    cfg_if.cfg_ftw_stop  = '0;
    cfg_if.cfg_ftw_step  = '0;
    cfg_if.cfg_dwell     = '0;
    cfg_if.cfg_repeat    = 1'b0;
    cfg_if.cfg_amplitude = '0;
    cfg_if.cfg_offset    = '0;
    repeat (3) tick();
    chk("rst_dac", dac_out, 0);
    chk("rst_ftw", ftw_current, 0);
    chk("rst_ready", cfg_if.cfg_ready, 1);
    chk("rst_wrap", phase_wrap, 0);
    chk("rst_done", sweep_done, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      enable = 1'b0;
      repeat (2) tick();
      send_cfg(vt[i].mode, vt[i].ftw, 0, 0, 0, 0,
               vt[i].amp, vt[i].off);
      repeat (5) tick();
      chk($sformatf("v%0d_idle_off", i), dac_out, vt[i].off);
      enable = 1'b1;
      repeat (8) tick();
      mn = 255; mx = 0; nw = 0;
      repeat (64) begin
        tick();
        if (int'(dac_out) < mn) mn = int'(dac_out);
        if (int'(dac_out) > mx) mx = int'(dac_out);
        if (phase_wrap) nw++;
      end
      chk($sformatf("v%0d_min", i), mn, vt[i].emin);
      chk($sformatf("v%0d_max", i), mx, vt[i].emax);
      chk($sformatf("v%0d_wraps", i), nw, vt[i].ewrap);
    end

    // enable-to-first-sample latency
    enable = 1'b0;
    repeat (2) tick();
    send_cfg(MODE_SQUARE, 32'h0800_0000, 0, 0, 0, 0, 255, 250);
    repeat (5) tick();
    enable = 1'b1;
    repeat (4) tick();
    chk("lat_e3_still_off", dac_out, 250);
    tick();
    chk("lat_e4_first", dac_out, 255);

    // linear sweep, no repeat
    enable = 1'b0;
    repeat (2) tick();
    send_cfg(MODE_SWEEP, 32'h100, 32'h400, 32'h100, 3, 0, 50, 100);
    tick();
    chk("sweep_start_ftw", ftw_current, 32'h100);
    enable = 1'b1;
    n2 = 0; n3 = 0; nd = 0; fd = '0;
    repeat (30) begin
      tick();
      if (ftw_current == 32'h200) n2++;
      if (ftw_current == 32'h300) n3++;
      if (sweep_done) begin
        nd++;
        fd = ftw_current;
      end
    end
    chk("sweep_hold_200", n2, 4);
    chk("sweep_hold_300", n3, 4);
    chk("sweep_done_cnt", nd, 1);
    chk("sweep_done_ftw", fd, 32'h400);
    chk("sweep_hold_ftw", ftw_current, 32'h400);

    // disable in the middle of a repeating sweep
    enable = 1'b0;
    repeat (2) tick();
    send_cfg(MODE_SWEEP, 32'h1000_0000, 32'h4000_0000,
             32'h0800_0000, 1, 1, 100, 60);
    repeat (5) tick();
    enable = 1'b1;
    repeat (10) tick();
    enable = 1'b0;
    repeat (4) tick();
    chk("disable_off", dac_out, 60);

    // reconfigure while running; apply waits for the wrap
    repeat (2) tick();
    send_cfg(MODE_SQUARE, 32'h0800_0000, 0, 0, 0, 0, 64, 128);
    repeat (5) tick();
    enable = 1'b1;
    n = 0;
    while (!phase_wrap && n < 100) begin
      tick();
      n++;
    end
    chk("first_wrap_seen", phase_wrap, 1);
    send_cfg(MODE_SQUARE, 32'h0800_0000, 0, 0, 0, 0, 128, 128);
    chk("ready_low_accept", cfg_if.cfg_ready, 0);
    cfg_if.cfg_amplitude = 8'd32;
    cfg_if.cfg_valid     = 1'b1;
    repeat (3) tick();
    cfg_if.cfg_valid     = 1'b0;
    n = 0; bad = 0;
    while (!phase_wrap && n < 100) begin
      if (cfg_if.cfg_ready) bad++;
      tick();
      n++;
    end
    chk("apply_wrap_seen", phase_wrap, 1);
    chk("ready_low_pending", bad, 0);
    chk("ready_at_wrap", cfg_if.cfg_ready, 1);
    repeat (2) tick();
    chk("old_amp_wrap2", dac_out, 64);
    tick();
    chk("new_amp_wrap3", dac_out, 255);
    mn = 255; mx = 0;
    repeat (32) begin
      tick();
      if (int'(dac_out) < mn) mn = int'(dac_out);
      if (int'(dac_out) > mx) mx = int'(dac_out);
    end
    chk("reconf_min", mn, 1);
    chk("reconf_max", mx, 255);

    // async reset mid-cycle with a config pending
    send_cfg(MODE_SQUARE, 32'h0800_0000, 0, 0, 0, 0, 10, 20);
    chk("pending_before_rst", cfg_if.cfg_ready, 0);
    repeat (2) tick();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_dac", dac_out, 0);
    chk("arst_ftw", ftw_current, 0);
    chk("arst_ready", cfg_if.cfg_ready, 1);
    chk("arst_wrap", phase_wrap, 0);
    chk("arst_done", sweep_done, 0);
    enable = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("post_rst_dac", dac_out, 0);
    chk("post_rst_ftw", ftw_current, 0);
    chk("post_rst_ready", cfg_if.cfg_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
